// File: rtl/traffic_phase_controller.sv
// Round-robin signal-head sequencer for a 4-way junction: GREEN -> YELLOW -> ALLRED per
// change of right-of-way, timed by a tick-enabled down-counter. All outputs registered.
//   state     | meaning
//   ST_GREEN  | road 'active' has green; others red
//   ST_YELLOW | road 'active' has yellow; others red
//   ST_ALLRED | all roads red (clearance before next green)
module traffic_phase_controller #(
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] req,
  output logic [3:0] r,
  output logic [3:0] y,
  output logic [3:0] g,
  output logic [1:0] active,
  output logic       grant_p
);

  typedef enum logic [1:0] {ST_GREEN, ST_YELLOW, ST_ALLRED} state_t;

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       nxt_q, nxt_d;
  logic [1:0]       active_d;
  logic             grant_d;
  logic [3:0]       r_d, y_d, g_d;
  logic [1:0]       pick;
  logic             pick_found;

  // First requesting road after the active one; req[active] is never considered.
  always_comb begin
    logic [1:0] idx;
    pick       = active;
    pick_found = 1'b0;
    idx        = active;
    for (int i = 1; i < 4; i++) begin
      idx = active + 2'(i);
      if (!pick_found && req[idx]) begin
        pick       = idx;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nxt_d    = nxt_q;
    active_d = active;
    grant_d  = 1'b0;
    if (tick) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        case (state_q)
          ST_GREEN: begin
            // Without a competing request the green extends with cnt parked at 0.
            if (pick_found) begin
              state_d = ST_YELLOW;
              cnt_d   = YELLOW_LD;
              nxt_d   = pick;
            end
          end
          ST_YELLOW: begin
            state_d = ST_ALLRED;
            cnt_d   = ALLRED_LD;
          end
          ST_ALLRED: begin
            state_d  = ST_GREEN;
            cnt_d    = GREEN_LD;
            active_d = nxt_q;
            grant_d  = 1'b1;
          end
          default: begin
            state_d = ST_ALLRED;
            cnt_d   = ALLRED_LD;
          end
        endcase
      end
    end

    // Lamps decoded from the next state so they switch on the transition edge.
    r_d = 4'b1111;
    y_d = 4'b0000;
    g_d = 4'b0000;
    case (state_d)
      ST_GREEN: begin
        g_d[active_d] = 1'b1;
        r_d[active_d] = 1'b0;
      end
      ST_YELLOW: begin
        y_d[active_d] = 1'b1;
        r_d[active_d] = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ALLRED;
      cnt_q   <= ALLRED_LD;
      nxt_q   <= 2'd0;
      active  <= 2'd0;
      grant_p <= 1'b0;
      r       <= 4'b1111;
      y       <= 4'b0000;
      g       <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nxt_q   <= nxt_d;
      active  <= active_d;
      grant_p <= grant_d;
      r       <= r_d;
      y       <= y_d;
      g       <= g_d;
    end
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller with short phases (G=3, Y=2, AR=1 ticks)
// plus a per-cycle lamp-sequencing monitor.
module tb_traffic_phase_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] req;
  logic [3:0] r, y, g;
  logic [1:0] active;
  logic       grant_p;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  traffic_phase_controller #(
    .GREEN_TICKS (3),
    .YELLOW_TICKS(2),
    .ALLRED_TICKS(1),
    .CNT_W       (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .req    (req),
    .r      (r),
    .y      (y),
    .g      (g),
    .active (active),
    .grant_p(grant_p)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {r,y,g}; ph 0=green, 1=yellow, 2=all-red.
  function automatic logic [11:0] exp_lamps(input int ph, input int road);
    logic [3:0] er, ey, eg;
    er = 4'b1111;
    ey = 4'b0000;
    eg = 4'b0000;
    if (ph == 0) begin
      eg[road] = 1'b1;
      er[road] = 1'b0;
    end else if (ph == 1) begin
      ey[road] = 1'b1;
      er[road] = 1'b0;
    end
    return {er, ey, eg};
  endfunction

  task automatic wait_grant(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (grant_p === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Per-cycle invariants: one lamp per road, one non-red road, grant only on green entry,
  // green entered only from all-red, never green-to-green.
  logic [3:0] prev_r = 4'b1111;
  logic [3:0] prev_g = 4'b0000;
  always @(negedge clk) begin
    if (mon_en) begin
      bit bad;
      int nonred;
      bad = 1'b0;
      nonred = 0;
      for (int i = 0; i < 4; i++) begin
        if ($countones({r[i], y[i], g[i]}) != 1) bad = 1'b1;
        if (r[i] !== 1'b1) nonred++;
      end
      if (nonred > 1) bad = 1'b1;
      if (grant_p !== ((g != 4'b0) && (prev_g == 4'b0))) bad = 1'b1;
      if ((prev_g != 4'b0) && (g != 4'b0) && (g !== prev_g)) bad = 1'b1;
      if ((prev_g == 4'b0) && (g != 4'b0) && (prev_r !== 4'b1111)) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL monitor t=%0t r=%b y=%b g=%b grant_p=%b prev_r=%b prev_g=%b",
                 $time, r, y, g, grant_p, prev_r, prev_g);
      end
      prev_r = r;
      prev_g = g;
    end
  end

  task automatic test_reset();
    int bad_cnt;
    rst = 1'b1; tick = 1'b1; req = 4'b0000;
    step();
    mon_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({r, y, g, active, grant_p} !== {4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0}) begin
        errors++;
        $display("FAIL reset_values r=%b y=%b g=%b active=%0d grant_p=%b, want r=1111 y=0000 g=0000 active=0 grant_p=0",
                 r, y, g, active, grant_p);
      end
      if (i == 0) step();
    end
    rst = 1'b0;
    step();
    checks++;
    if ({r, g, active, grant_p} !== {4'b1110, 4'b0001, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL first_green r=%b g=%b active=%0d grant_p=%b, want r=1110 g=0001 active=0 grant_p=1",
               r, g, active, grant_p);
    end
    bad_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (g !== 4'b0001 || grant_p !== 1'b0) bad_cnt++;
    end
    checks++;
    if (bad_cnt != 0) begin
      errors++;
      $display("FAIL green_hold bad_cycles=%0d, want 0 (g=0001 for 50 cycles)", bad_cnt);
    end
  endtask

  task automatic test_switch_from_extension();
    logic [11:0] want [4];
    want[0] = exp_lamps(1, 0);
    want[1] = exp_lamps(1, 0);
    want[2] = exp_lamps(2, 0);
    want[3] = exp_lamps(0, 2);
    req = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({r, y, g} !== want[i]) begin
        errors++;
        $display("FAIL ext_switch cycle=%0d ryg=%b, want %b", i, {r, y, g}, want[i]);
      end
    end
    checks++;
    if (active !== 2'd2 || grant_p !== 1'b1) begin
      errors++;
      $display("FAIL ext_switch_grant active=%0d grant_p=%b, want active=2 grant_p=1", active, grant_p);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    req = 4'b1000;
    wait_grant(20, ok);
    checks++;
    if (!ok || active !== 2'd3) begin
      errors++;
      $display("FAIL rr_setup granted=%0d active=%0d, want granted=1 active=3", ok, active);
    end
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 6; s++) begin
        logic [11:0] w;
        if (!(k == 0 && s == 0)) step();
        w = exp_lamps((s < 3) ? 0 : (s < 5) ? 1 : 2, (3 + k) % 4);
        checks++;
        if ({r, y, g} !== w) begin
          errors++;
          $display("FAIL rr_seq road=%0d slot=%0d ryg=%b, want %b", (3 + k) % 4, s, {r, y, g}, w);
        end
      end
    end
    step();
    checks++;
    if (g !== 4'b1000 || active !== 2'd3 || grant_p !== 1'b1) begin
      errors++;
      $display("FAIL rr_wrap g=%b active=%0d grant_p=%b, want g=1000 active=3 grant_p=1", g, active, grant_p);
    end
  endtask

  task automatic test_pulsed_request();
    bit ok;
    logic [11:0] want [3];
    req = 4'b0001;
    wait_grant(20, ok);
    checks++;
    if (!ok || active !== 2'd0) begin
      errors++;
      $display("FAIL pulse_setup granted=%0d active=%0d, want granted=1 active=0", ok, active);
    end
    req = 4'b0000;
    step();
    step();
    req = 4'b0010;
    step();
    req = 4'b0000;
    checks++;
    if ({r, y, g} !== exp_lamps(1, 0)) begin
      errors++;
      $display("FAIL pulse_yellow ryg=%b, want %b", {r, y, g}, exp_lamps(1, 0));
    end
    want[0] = exp_lamps(1, 0);
    want[1] = exp_lamps(2, 0);
    want[2] = exp_lamps(0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({r, y, g} !== want[i]) begin
        errors++;
        $display("FAIL pulse_seq cycle=%0d ryg=%b, want %b", i, {r, y, g}, want[i]);
      end
    end
    checks++;
    if (active !== 2'd1 || grant_p !== 1'b1) begin
      errors++;
      $display("FAIL pulse_grant active=%0d grant_p=%b, want active=1 grant_p=1", active, grant_p);
    end
  endtask

  task automatic test_tick_freeze();
    int bad_cnt;
    logic [11:0] want [3];
    req = 4'b0100;
    step();
    step();
    step();
    checks++;
    if ({r, y, g} !== exp_lamps(1, 1)) begin
      errors++;
      $display("FAIL freeze_enter ryg=%b, want %b", {r, y, g}, exp_lamps(1, 1));
    end
    tick = 1'b0;
    bad_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if ({r, y, g} !== exp_lamps(1, 1)) bad_cnt++;
    end
    checks++;
    if (bad_cnt != 0) begin
      errors++;
      $display("FAIL freeze_hold bad_cycles=%0d, want 0", bad_cnt);
    end
    tick = 1'b1;
    want[0] = exp_lamps(1, 1);
    want[1] = exp_lamps(2, 1);
    want[2] = exp_lamps(0, 2);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({r, y, g} !== want[i]) begin
        errors++;
        $display("FAIL freeze_resume cycle=%0d ryg=%b, want %b", i, {r, y, g}, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid_yellow();
    bit ok;
    req = 4'b0010;
    wait_grant(20, ok);
    checks++;
    if (!ok || active !== 2'd1) begin
      errors++;
      $display("FAIL midrst_setup granted=%0d active=%0d, want granted=1 active=1", ok, active);
    end
    req = 4'b0100;
    step();
    step();
    step();
    checks++;
    if ({r, y, g} !== exp_lamps(1, 1)) begin
      errors++;
      $display("FAIL midrst_yellow ryg=%b, want %b", {r, y, g}, exp_lamps(1, 1));
    end
    rst = 1'b1;
    step();
    checks++;
    if ({r, y, g, active, grant_p} !== {4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_values r=%b y=%b g=%b active=%0d grant_p=%b, want r=1111 y=0000 g=0000 active=0 grant_p=0",
               r, y, g, active, grant_p);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({g, active, grant_p} !== {4'b0001, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL midrst_recover g=%b active=%0d grant_p=%b, want g=0001 active=0 grant_p=1",
               g, active, grant_p);
    end
  endtask

  initial begin
    test_reset();
    test_switch_from_extension();
    test_round_robin();
    test_pulsed_request();
    test_tick_freeze();
    test_reset_mid_yellow();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
